// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, error codes,
// common keyboard commands and the host frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // {stop, odd parity, data}; shifted out LSB first
  function automatic logic [9:0] ps2_frame(
    input logic [7:0] d
  );
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins,
// with falling-edge detect on the synchronized clock.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic sync_clk,
  output logic sync_dat,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       prev_clk;

  // Idle bus is high, so the chains reset to 1
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      prev_clk <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_in};
      dat_ff   <= {dat_ff[0], dat_in};
      prev_clk <= clk_ff[1];
    end
  end

  assign sync_clk = clk_ff[1];
  assign sync_dat = dat_ff[1];
  assign fall     = prev_clk & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Optional one-shot retry: define PS2_HOST_TX_RETRY_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int RTS_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] tx_err_code
);

  localparam int PMAX = (INHIBIT_CYCLES > RTS_CYCLES) ?
                        INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PW = $clog2(PMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [9:0]    shift;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;

  logic sync_clk;
  logic sync_dat;
  logic fall;

  logic       line_idle;
  logic       in_xfer;
  logic       nack;
  logic       tmo;
  logic       fail;
  logic [1:0] fail_code;

`ifdef PS2_HOST_TX_RETRY_EN
  logic       retried;
  logic [7:0] byte_q;
`endif

  ps2_line_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .sync_clk (sync_clk),
    .sync_dat (sync_dat),
    .fall     (fall)
  );

  // Failure detection: NACK on the ack edge or a stalled device
  always_comb begin
    line_idle = sync_clk & sync_dat;
    in_xfer   = (state == SEND) || (state == ACK) ||
                (state == WAIT_IDLE);
    nack      = (state == ACK) && fall && sync_dat;
    tmo       = in_xfer && !fall &&
                (tcnt == TW'(TIMEOUT_CYCLES - 1)) &&
                !((state == WAIT_IDLE) && line_idle);
    fail      = nack || tmo;
    fail_code = nack ? ERR_NACK : ERR_TIMEOUT;
  end

  assign rx_inhibit = ~tx_ready;

  // Transfer sequencer with registered line enables and pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      pcnt        <= '0;
      tcnt        <= '0;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_dat_oe  <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      tx_err_code <= ERR_NONE;
`ifdef PS2_HOST_TX_RETRY_EN
      retried     <= 1'b0;
      byte_q      <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
        if (!retried) begin
          retried    <= 1'b1;
          state      <= INHIBIT;
          shift      <= ps2_frame(byte_q);
          bit_cnt    <= '0;
          pcnt       <= '0;
          ps2_clk_oe <= 1'b1;
          ps2_dat_oe <= 1'b0;
        end else begin
          state       <= ERROR;
          tx_error    <= 1'b1;
          tx_err_code <= fail_code;
          ps2_clk_oe  <= 1'b0;
          ps2_dat_oe  <= 1'b0;
        end
`else
        state       <= ERROR;
        tx_error    <= 1'b1;
        tx_err_code <= fail_code;
        ps2_clk_oe  <= 1'b0;
        ps2_dat_oe  <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (tx_valid && tx_ready) begin
              state      <= INHIBIT;
              shift      <= ps2_frame(tx_data);
              bit_cnt    <= '0;
              pcnt       <= '0;
              tx_ready   <= 1'b0;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
              retried    <= 1'b0;
              byte_q     <= tx_data;
`endif
            end
          end
          INHIBIT: begin
            if (pcnt == PW'(INHIBIT_CYCLES - 1)) begin
              state      <= RTS;
              pcnt       <= '0;
              ps2_dat_oe <= 1'b1;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
          RTS: begin
            if (pcnt == PW'(RTS_CYCLES - 1)) begin
              state      <= SEND;
              pcnt       <= '0;
              tcnt       <= '0;
              ps2_clk_oe <= 1'b0;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
          SEND: begin
            if (fall) begin
              ps2_dat_oe <= ~shift[0];
              shift      <= {1'b0, shift[9:1]};
              bit_cnt    <= bit_cnt + 4'd1;
              tcnt       <= '0;
              if (bit_cnt == 4'd9) begin
                state <= ACK;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          ACK: begin
            if (fall) begin
              tcnt  <= '0;
              state <= WAIT_IDLE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          WAIT_IDLE: begin
            if (line_idle) begin
              state   <= DONE;
              tx_done <= 1'b1;
            end else if (fall) begin
              tcnt <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          DONE: begin
            state    <= IDLE;
            tx_ready <= 1'b1;
          end
          ERROR: begin
            state    <= IDLE;
            tx_ready <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed + random bench for ps2_host_tx with a PS/2
// device model on the open-collector lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int RTSC = 10;
  localparam int TMO  = 3000;
  localparam int HALF = 20;
  localparam int LIM  = TMO + 500;

  logic       clock;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       rx_inhibit;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] tx_err_code;

  logic dev_clk;
  logic dev_dat;

  int passed;
  int total;
  int done_cnt;
  int err_cnt;
  logic [1:0] err_oe;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTSC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_dat_in  (ps2_dat_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_dat_oe  (ps2_dat_oe),
    .rx_inhibit  (rx_inhibit),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .tx_err_code (tx_err_code)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  initial begin
    done_cnt = 0;
    err_cnt  = 0;
    err_oe   = 2'b00;
  end

  always @(negedge clock) begin
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_oe = {ps2_clk_oe, ps2_dat_oe};
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Line frame as seen on the wire: start, data, parity, stop
  function automatic logic [10:0] model_frame(
    input logic [7:0] d
  );
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < LIM) begin
      tick(1);
      n++;
    end
    if (n >= LIM) check("ready_bound", 0, 1);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < LIM) begin
      tick(1);
      n++;
    end
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < LIM) begin
      tick(1);
      n++;
    end
    if (n >= LIM) check("release_bound", 0, 1);
  endtask

  task automatic send(input logic [7:0] d);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check("acc_ready", tx_ready, 0);
    check("acc_clk_oe", ps2_clk_oe, 1);
    check("acc_inhibit", rx_inhibit, 1);
  endtask

  task automatic device(input int nfall, input bit ack,
                        output logic [10:0] bits);
    int n;
    bits = '0;
    wait_release(n);
    tick(HALF);
    bits[0] = ps2_dat_in;
    for (int i = 1; i <= nfall; i++) begin
      dev_clk = 1'b0;
      tick(HALF);
      bits[i] = ps2_dat_in;
      dev_clk = 1'b1;
      tick(HALF);
    end
    if (nfall == 10) begin
      dev_dat = ack ? 1'b0 : 1'b1;
      tick(HALF);
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      tick(4);
      dev_dat = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic xfer(input logic [7:0] d);
    logic [10:0] bits;
    logic [10:0] exp;
    int d0;
    d0  = done_cnt;
    exp = model_frame(d);
    send(d);
    device(10, 1'b1, bits);
    wait_ready();
    check("frame", bits, exp);
    check("parity", bits[9], exp[9]);
    check("done_once", done_cnt - d0, 1);
    check("ready_back", tx_ready, 1);
  endtask

  initial begin
    logic [10:0] bits;
    int d0;
    int e0;
    int n;
    passed   = 0;
    total    = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    tick(3);
    check("rst_ready", tx_ready, 1);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_inhibit", rx_inhibit, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_code", tx_err_code, 0);
    reset = 1'b0;
    tick(2);

    xfer(CMD_SET_LEDS);
    xfer(8'h01);
    xfer(CMD_RESET);
    for (int i = 0; i < 4; i++) begin
      xfer(8'($urandom_range(0, 255)));
    end

    // Device refuses the byte
    e0 = err_cnt;
    send(8'hA5);
    device(10, 1'b0, bits);
`ifdef PS2_HOST_TX_RETRY_EN
    device(10, 1'b0, bits);
`endif
    wait_ready();
    check("nack_err", err_cnt - e0, 1);
    check("nack_code", tx_err_code, ERR_NACK);
    check("nack_oe", err_oe, 2'b00);
    xfer(8'h3C);
    check("code_hold", tx_err_code, ERR_NACK);

    // Device never clocks
    e0 = err_cnt;
    send(8'h12);
    wait_release(n);
`ifdef PS2_HOST_TX_RETRY_EN
    wait_release(n);
`endif
    n = 0;
    while (tx_error !== 1'b1 && n < TMO + 100) begin
      tick(1);
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_code", tx_err_code, ERR_TIMEOUT);
    check("tmo_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    wait_ready();
    check("tmo_err", err_cnt - e0, 1);

    // Reset after four data bits
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h96);
    device(4, 1'b1, bits);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("mid_ready", tx_ready, 1);
    check("mid_inhibit", rx_inhibit, 0);
    tick(20);
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_no_err", err_cnt - e0, 0);

    // Valid held during a transfer: no queueing
    d0 = done_cnt;
    tx_data  = CMD_SET_LEDS;
    tx_valid = 1'b1;
    tick(1);
    tx_data  = 8'h55;
    device(10, 1'b1, bits);
    check("held_first", bits, model_frame(CMD_SET_LEDS));
    n = 0;
    while (done_cnt == d0 && n < LIM) begin
      tick(1);
      n++;
    end
    n = 0;
    while (tx_ready !== 1'b0 && n < LIM) begin
      tick(1);
      n++;
    end
    tx_valid = 1'b0;
    check("held_accept", tx_ready, 0);
    device(10, 1'b1, bits);
    wait_ready();
    check("held_second", bits, model_frame(8'h55));
    check("held_done", done_cnt - d0, 2);

`ifdef PS2_HOST_TX_RETRY_EN
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h5A);
    device(10, 1'b0, bits);
    check("retry_busy", tx_ready, 0);
    device(10, 1'b1, bits);
    wait_ready();
    check("retry_frame", bits, model_frame(8'h5A));
    check("retry_done", done_cnt - d0, 1);
    check("retry_no_err", err_cnt - e0, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Complements the existing PS/2 receive path. Sits beside key_driver behind the keyboard io_interface.
- Drives the open-collector PS2_CLK/PS2_DAT lines through active-high pull-low enables. Asserts rx_inhibit so the receive path ignores the line during a transmission.

Parameters:
- INHIBIT_CYCLES, 6000: clock-low hold before request-to-send; 120 us at 50 MHz.
- RTS_CYCLES, 100: cycles with clk and dat both held low before clk is released.
- TIMEOUT_CYCLES, 1000000: maximum cycles between device clock falling edges (20 ms).

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  block idle, can accept a byte
- ps2_clk_in  in  1  raw PS2_CLK pin (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pin (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_dat_oe  out  1  1 = pull PS2_DAT low
- rx_inhibit  out  1  1 while a transmission is in progress
- tx_done  out  1  one-cycle pulse: byte ACKed by device
- tx_error  out  1  one-cycle pulse: transfer failed
- tx_err_code  out  2  valid with tx_error: 01 timeout, 10 NACK; holds its last value otherwise

Behaviour:
- Interface decided: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, rx_inhibit=0, tx_done=0, tx_error=0, tx_err_code=00, state IDLE.
- A reset asserted mid-frame releases both lines on the next edge; no done or error pulse is produced.
- Pin inputs pass through a 2-flop synchronizer. fall = prev_sync_clk & ~sync_clk.
- Accept condition: tx_valid & tx_ready.
  - Latches the byte and shift register = {stop=1, parity=~^tx_data, data[7:0]}.
  - Clears bit_cnt.
  - tx_ready falls and ps2_clk_oe rises on the next cycle.
  - tx_valid while not ready is ignored; no queueing.
- IDLE: tx_ready=1, oe=0/0. Goes to INHIBIT on accept.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES cycles, then RTS.
- RTS: clk_oe=1, dat_oe=1 (start bit) for RTS_CYCLES cycles, then SEND with clk_oe=0.
- SEND:
  - On each fall, dat_oe = ~shift[0], then shift right and bit_cnt++.
  - Falls 1-8 carry data LSB first, fall 9 carries parity, fall 10 releases the line (stop).
  - After fall 10, go to ACK.
- ACK:
  - On the next fall, sample sync_dat: 0 means ACK, go to WAIT_IDLE; 1 means NACK, go to ERROR with code 10.
- WAIT_IDLE: wait until sync_clk=1 and sync_dat=1, then DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- ERROR: tx_error=1 for one cycle, both oe=0, then IDLE.
- Timeout: the counter clears on entering SEND and on every fall. Reaching TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE forces ERROR with code 01 and releases lines immediately.
- rx_inhibit = ~tx_ready.
- A fall seen during INHIBIT or RTS is ignored.

Optional Feature:
- Macro PS2_HOST_TX_RETRY_EN.
- Defined: the first NACK or timeout silently restarts at INHIBIT with the same byte. tx_error is reported only if the retry also fails. rx_inhibit stays high throughout.
- Undefined: the first failure goes straight to ERROR.

Decomposition:
- Package ps2_pkg holds:
  - state enum typedef (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE, ERROR);
  - err code localparams ERR_NONE=00, ERR_TIMEOUT=01, ERR_NACK=10;
  - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF.
- Sub-module ps2_line_sync: 2-flop synchronizer for clk and dat, outputs sync_clk, sync_dat and fall. Shareable with key_driver.

Test Plan:
- Send 0xED, device model clocks at 12.5 kHz and ACKs -> dat_oe pattern after the start bit is 1,0,1,1,0,1,1,1 LSB first, parity 1, stop released; tx_done pulses once; tx_ready returns to 1.
- Send 0x01 -> parity 0 (dat_oe=1 on fall 9). Send 0xFF -> parity 1.
- Device leaves dat high on the ACK edge -> tx_error=1, tx_err_code=10, both oe=0.
- Device never clocks after RTS -> after exactly TIMEOUT_CYCLES, tx_error with code 01.
- Reset asserted after 4 data bits -> oe=0/0 and tx_ready=1 next cycle; no done or error pulse.
- tx_valid held high with 0x55 during a 0xED transfer -> only 0xED is sent; 0x55 is accepted after tx_done.
- With PS2_HOST_TX_RETRY_EN: NACK once, then ACK -> INHIBIT is re-entered, no tx_error, a single tx_done.
